// File: rtl/rv32_decode_stage_pkg.sv
// ============================================================================
//  Module      : rv32_decode_stage_pkg
//  Description : Shared types for the RV32IM decode stage: control record,
//                trap cause, field encodings and the NOP control default.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_decode_stage_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_REG   = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MEXT = 7'h01;

    // ALU operation; branches use ALU_SUB as the compare, LUI uses ALU_PASSB
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_MEXT = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    // Encoded identically to the load/store funct3 field
    typedef enum logic [2:0] {
        MEM_BYTE  = 3'd0,
        MEM_HALF  = 3'd1,
        MEM_WORD  = 3'd2,
        MEM_BYTEU = 3'd4,
        MEM_HALFU = 3'd5
    } mem_size_e;

    // Encoded identically to the M-extension funct3 field
    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_op_e;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'd0,
        TRAP_ILLEGAL = 2'd1,
        TRAP_ECALL   = 2'd2,
        TRAP_EBREAK  = 2'd3
    } trap_cause_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      alu_src;
        alu_op_e   alu_op;
        wb_sel_e   wb_sel;
        logic      branch_en;
        logic      jump;
        logic      is_jalr;
        imm_type_e imm_type;
        mem_size_e mem_size;
        logic      m_valid;
        m_op_e     m_op;
    } decode_ctrl_t;

    localparam decode_ctrl_t DECODE_NOP = '{
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_src:   1'b0,
        alu_op:    ALU_ADD,
        wb_sel:    WB_ALU,
        branch_en: 1'b0,
        jump:      1'b0,
        is_jalr:   1'b0,
        imm_type:  IMM_I,
        mem_size:  MEM_WORD,
        m_valid:   1'b0,
        m_op:      M_MUL
    };

    // Integer ALU operation from funct3; alt selects SUB (funct3=0) or SRA (funct3=5)
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_decode_logic.sv
// ============================================================================
//  Module      : rv32_decode_logic
//  Description : Purely combinational RV32IM instruction decoder producing
//                the control record plus illegal/trap flags and cause.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_decode_logic
    import rv32_decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int EN_MEXT = 1,
    parameter int EN_TRAP = 1
) (
    input  logic [XLEN-1:0] instr,
    output decode_ctrl_t    ctrl,
    output logic            illegal,
    output logic            trap,
    output trap_cause_e     cause
);

    logic [6:0]   w_opcode;
    logic [2:0]   w_funct3;
    logic [6:0]   w_funct7;
    decode_ctrl_t w_ctrl;
    logic         w_illegal;
    logic         w_ecall;
    logic         w_ebreak;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    // Per-opcode control fields and legality checks
    always_comb begin
        w_ctrl    = DECODE_NOP;
        w_illegal = 1'b0;
        w_ecall   = 1'b0;
        w_ebreak  = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = ALU_PASSB;
                w_ctrl.imm_type  = IMM_U;
            end
            OPC_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.imm_type  = IMM_U;
            end
            OPC_JAL: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.imm_type  = IMM_J;
                w_ctrl.wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                w_illegal        = (w_funct3 != 3'd0);
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.is_jalr   = 1'b1;
                w_ctrl.imm_type  = IMM_I;
                w_ctrl.wb_sel    = WB_PC4;
            end
            OPC_BRANCH: begin
                w_illegal        = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
                w_ctrl.branch_en = 1'b1;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.imm_type  = IMM_B;
            end
            OPC_LOAD: begin
                w_illegal        = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
                w_ctrl.reg_write = 1'b1;
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.wb_sel    = WB_MEM;
                w_ctrl.mem_size  = mem_size_e'(w_funct3);
            end
            OPC_STORE: begin
                w_illegal        = (w_funct3 > 3'd2);
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.imm_type  = IMM_S;
                w_ctrl.mem_size  = mem_size_e'(w_funct3);
            end
            OPC_OP_IMM: begin
                if (w_funct3 == 3'd1) begin
                    w_illegal = (w_funct7 != F7_BASE);
                end else if (w_funct3 == 3'd5) begin
                    w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
                end
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_op    = alu_from_funct3(w_funct3,
                                                   (w_funct3 == 3'd5) && (w_funct7 == F7_ALT));
            end
            OPC_OP_REG: begin
                w_ctrl.reg_write = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    w_ctrl.alu_op = alu_from_funct3(w_funct3, 1'b0);
                end else if (w_funct7 == F7_ALT) begin
                    w_illegal     = (w_funct3 != 3'd0) && (w_funct3 != 3'd5);
                    w_ctrl.alu_op = alu_from_funct3(w_funct3, 1'b1);
                end else if (w_funct7 == F7_MEXT) begin
                    w_illegal      = (EN_MEXT == 0);
                    w_ctrl.m_valid = 1'b1;
                    w_ctrl.m_op    = m_op_e'(w_funct3);
                    w_ctrl.wb_sel  = WB_MEXT;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE: ordering is trivially satisfied in-order, decode as NOP
            end
            OPC_SYSTEM: begin
                w_ecall   = (instr == INSTR_ECALL);
                w_ebreak  = (instr == INSTR_EBREAK);
                w_illegal = !(w_ecall || w_ebreak);
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Resolve trap/cause; any faulting or trapping entry carries a NOP record
    always_comb begin
        illegal = w_illegal;
        trap    = (EN_TRAP != 0) && (w_ecall || w_ebreak);
        ctrl    = (illegal || trap) ? DECODE_NOP : w_ctrl;
        if (illegal) begin
            cause = TRAP_ILLEGAL;
        end else if (trap && w_ecall) begin
            cause = TRAP_ECALL;
        end else if (trap) begin
            cause = TRAP_EBREAK;
        end else begin
            cause = TRAP_NONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32_decode_stage.sv
// ============================================================================
//  Module      : rv32_decode_stage
//  Description : Registered decode stage: decodes fetched instructions at
//                push time and buffers the results in a DEPTH-entry FIFO
//                between fetch and register-read/execute.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_decode_stage
    import rv32_decode_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int EN_MEXT = 1,
    parameter int EN_TRAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output decode_ctrl_t    out_ctrl,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal,
    output logic            out_trap,
    output trap_cause_e     out_trap_cause,
    output logic [31:0]     decode_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);

    typedef struct packed {
        decode_ctrl_t    ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            illegal;
        logic            trap;
        trap_cause_e     cause;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_decode_cnt;

    decode_ctrl_t     w_dec_ctrl;
    logic             w_dec_illegal;
    logic             w_dec_trap;
    trap_cause_e      w_dec_cause;
    entry_t           w_entry;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    rv32_decode_logic #(
        .XLEN    (XLEN),
        .EN_MEXT (EN_MEXT),
        .EN_TRAP (EN_TRAP)
    ) u_decode (
        .instr   (in_instr),
        .ctrl    (w_dec_ctrl),
        .illegal (w_dec_illegal),
        .trap    (w_dec_trap),
        .cause   (w_dec_cause)
    );

    // Readiness comes from occupancy only, keeping in->out paths registered
    assign in_ready  = (r_count < C_DEPTH);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Assemble the record stored for an accepted instruction
    always_comb begin
        w_entry.ctrl    = w_dec_ctrl;
        w_entry.pc      = in_pc;
        w_entry.instr   = in_instr;
        w_entry.rd      = in_instr[11:7];
        w_entry.rs1     = in_instr[19:15];
        w_entry.rs2     = in_instr[24:20];
        w_entry.illegal = w_dec_illegal;
        w_entry.trap    = w_dec_trap;
        w_entry.cause   = w_dec_cause;
    end

    // Entry storage; contents are masked on the output while invalid
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers and occupancy; flush drops both the queue and same-cycle traffic
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Count of entries handed to execute; discarded entries are not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_decode_cnt <= '0;
        end else if (w_pop && !flush) begin
            r_decode_cnt <= r_decode_cnt + 32'd1;
        end
    end

    // Head entry, or the defined idle payload when the buffer is empty
    always_comb begin
        w_head       = '0;
        w_head.ctrl  = DECODE_NOP;
        w_head.cause = TRAP_NONE;
        if (out_valid) begin
            w_head = r_mem[r_rd_ptr];
        end
    end

    assign out_ctrl       = w_head.ctrl;
    assign out_pc         = w_head.pc;
    assign out_instr      = w_head.instr;
    assign out_rd         = w_head.rd;
    assign out_rs1        = w_head.rs1;
    assign out_rs2        = w_head.rs2;
    assign out_illegal    = w_head.illegal;
    assign out_trap       = w_head.trap;
    assign out_trap_cause = w_head.cause;
    assign decode_cnt     = r_decode_cnt;

endmodule

`default_nettype wire
